// File: rtl/deskew_rx_pkg.sv
// Shared defaults and state encoding for the multi-lane receive deskew stage.
package deskew_rx_pkg;

  localparam int LANE_N_DFLT  = 4;
  localparam int BLOCK_W_DFLT = 66;
  localparam int SKEW_N_DFLT  = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'b001,
    WAIT_AM = 3'b010,
    ALIGNED = 3'b100
  } state_t;

endpackage

// File: rtl/deskew_fifo_rx.sv
// Single-lane register FIFO: externally managed write pointer, shared read pointer.
module deskew_fifo_rx
  import deskew_rx_pkg::*;
#(
  parameter int BLOCK_W = BLOCK_W_DFLT,
  parameter int SKEW_N  = SKEW_N_DFLT,
  parameter int PTR_W   = $clog2(SKEW_N_DFLT)
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [PTR_W-1:0]   wr_ptr,
  input  logic [BLOCK_W:0]   wr_data,
  input  logic [PTR_W-1:0]   rd_ptr,
  output logic [BLOCK_W:0]   rd_data
);

  // Storage is deliberately not reset; the controller never reads an unwritten slot.
  logic [BLOCK_W:0] mem [SKEW_N];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/deskew_rx.sv
// Lane deskew: buffers each lane from its alignment marker on, then reads all lanes in lockstep.
//
// state   | meaning
// IDLE    | not all lanes locked; nothing buffered
// WAIT_AM | lanes locked; each lane buffers from its first AM until every lane has one
// ALIGNED | common read pointer releases one aligned block per lane per valid cycle
module deskew_rx
  import deskew_rx_pkg::*;
#(
  parameter int LANE_N  = LANE_N_DFLT,
  parameter int BLOCK_W = BLOCK_W_DFLT,
  parameter int SKEW_N  = SKEW_N_DFLT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      valid_i,
  input  logic [LANE_N-1:0]         lock_v_i,
  input  logic [LANE_N-1:0]         am_v_i,
  input  logic [LANE_N*BLOCK_W-1:0] block_i,
  output logic                      valid_o,
  output logic [LANE_N*BLOCK_W-1:0] block_o,
  output logic                      am_o,
  output logic                      deskew_v_o
);

  localparam int PTR_W = (SKEW_N > 1) ? $clog2(SKEW_N) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(SKEW_N - 1);

  state_t                       state_q;
  logic [LANE_N-1:0][PTR_W-1:0] wptr_q;
  logic [PTR_W-1:0]             rptr_q;
  logic [LANE_N-1:0]            am_seen_q;

  logic [LANE_N-1:0]            am_seen_next;
  logic [LANE_N-1:0]            wr_en;
  logic [LANE_N-1:0]            rd_am;
  logic [LANE_N-1:0][BLOCK_W:0] rd_ent;
  logic [LANE_N*BLOCK_W-1:0]    rd_block;
  logic                         lock_all;
  logic                         in_wait;
  logic                         in_aligned;
  logic                         rd_en;
  logic                         am_done;
  logic                         overflow;
  logic                         wait_fail;
  logic                         am_all;
  logic                         am_mismatch;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign lock_all   = &lock_v_i;
  assign in_wait    = (state_q == WAIT_AM);
  assign in_aligned = (state_q == ALIGNED);
  assign rd_en      = in_aligned & valid_i;

  // While waiting, a lane starts storing at its own AM; the AM block is the first entry.
  always_comb begin
    wr_en        = '0;
    am_seen_next = am_seen_q;
    overflow     = 1'b0;
    if (in_wait) begin
      wr_en        = {LANE_N{valid_i}} & (am_seen_q | am_v_i);
      am_seen_next = am_seen_q | wr_en;
      for (int i = 0; i < LANE_N; i++) begin
        if (wr_en[i] && (wptr_q[i] == PTR_LAST)) overflow = 1'b1;
      end
    end else if (in_aligned) begin
      wr_en = {LANE_N{valid_i}};
    end
  end

  assign am_done     = &am_seen_next;
  assign wait_fail   = overflow & ~am_done;
  assign am_all      = &rd_am;
  assign am_mismatch = rd_en & (|rd_am) & ~am_all;

  for (genvar i = 0; i < LANE_N; i++) begin : g_lane
    deskew_fifo_rx #(
      .BLOCK_W (BLOCK_W),
      .SKEW_N  (SKEW_N),
      .PTR_W   (PTR_W)
    ) u_fifo (
      .clk     (clk),
      .wr_en   (wr_en[i]),
      .wr_ptr  (wptr_q[i]),
      .wr_data ({am_v_i[i], block_i[i*BLOCK_W +: BLOCK_W]}),
      .rd_ptr  (rptr_q),
      .rd_data (rd_ent[i])
    );
    assign rd_am[i]                        = rd_ent[i][BLOCK_W];
    assign rd_block[i*BLOCK_W +: BLOCK_W]  = rd_ent[i][BLOCK_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      wptr_q    <= '0;
      rptr_q    <= '0;
      am_seen_q <= '0;
      valid_o   <= 1'b0;
      am_o      <= 1'b0;
      block_o   <= '0;
    end else begin
      valid_o   <= rd_en & lock_all & ~am_mismatch;
      if (rd_en) begin
        block_o <= rd_block;
        am_o    <= am_all;
        rptr_q  <= ptr_inc(rptr_q);
      end
      for (int i = 0; i < LANE_N; i++) begin
        if (wr_en[i]) wptr_q[i] <= ptr_inc(wptr_q[i]);
      end
      am_seen_q <= am_seen_next;

      // Lock loss is checked first in every busy state so it wins over completion.
      unique case (state_q)
        IDLE: begin
          if (lock_all) begin
            state_q   <= WAIT_AM;
            wptr_q    <= '0;
            am_seen_q <= '0;
          end
        end
        WAIT_AM: begin
          if (!lock_all) begin
            state_q <= IDLE;
          end else if (am_done) begin
            state_q <= ALIGNED;
            rptr_q  <= '0;
          end else if (wait_fail) begin
            state_q <= IDLE;
          end
        end
        ALIGNED: begin
          if (!lock_all || am_mismatch) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign deskew_v_o = in_aligned;

endmodule

// File: tb/tb_deskew_rx.sv
// Bench for deskew_rx: cycle table, directed skew scenarios and random streams vs a queue model.
module tb_deskew_rx;

  localparam int LN  = 4;
  localparam int BW  = 66;
  localparam int SK  = 8;
  localparam int AMP = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             valid_i;
  logic [LN-1:0]    lock_v_i;
  logic [LN-1:0]    am_v_i;
  logic [LN*BW-1:0] block_i;
  logic             valid_o;
  logic [LN*BW-1:0] block_o;
  logic             am_o;
  logic             deskew_v_o;

  always #5 clk = ~clk;

  deskew_rx #(.LANE_N(LN), .BLOCK_W(BW), .SKEW_N(SK)) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_i    (valid_i),
    .lock_v_i   (lock_v_i),
    .am_v_i     (am_v_i),
    .block_i    (block_i),
    .valid_o    (valid_o),
    .block_o    (block_o),
    .am_o       (am_o),
    .deskew_v_o (deskew_v_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: per-lane queues and a three-way mode (0 idle, 1 waiting, 2 aligned).
  int               m_mode;
  logic [LN-1:0]    m_seen;
  logic [BW:0]      mq [LN][$];
  logic             e_valid, e_am, e_desk;
  logic [LN*BW-1:0] e_block;
  bit               seq_on = 0;
  longint           last_seq = -1;

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_vec(input string name, input logic [LN*BW-1:0] act, input logic [LN*BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_mode  = 0;
    m_seen  = '0;
    for (int i = 0; i < LN; i++) mq[i].delete();
    e_valid = 1'b0;
    e_am    = 1'b0;
    e_desk  = 1'b0;
    e_block = '0;
  endfunction

  function automatic void model_step();
    logic          lock_all;
    logic          ovf;
    logic [LN-1:0] flags;
    logic [BW:0]   ent;
    lock_all = &lock_v_i;
    ovf      = 1'b0;
    flags    = '0;
    e_valid  = 1'b0;
    case (m_mode)
      0: begin
        if (lock_all) begin
          m_mode = 1;
          m_seen = '0;
          for (int i = 0; i < LN; i++) mq[i].delete();
        end
      end
      1: begin
        if (!lock_all) m_mode = 0;
        else begin
          for (int i = 0; i < LN; i++) begin
            if (valid_i && (m_seen[i] || am_v_i[i])) begin
              mq[i].push_back({am_v_i[i], block_i[i*BW +: BW]});
              m_seen[i] = 1'b1;
              if (mq[i].size() >= SK) ovf = 1'b1;
            end
          end
          if (&m_seen) m_mode = 2;
          else if (ovf) m_mode = 0;
        end
      end
      default: begin
        if (valid_i) begin
          for (int i = 0; i < LN; i++) begin
            if (mq[i].size() == 0) ent = '0;
            else ent = mq[i].pop_front();
            flags[i] = ent[BW];
            e_block[i*BW +: BW] = ent[BW-1:0];
            mq[i].push_back({am_v_i[i], block_i[i*BW +: BW]});
          end
          e_am    = &flags;
          e_valid = lock_all && ((flags == '0) || (&flags));
          if (!e_valid) m_mode = 0;
        end else if (!lock_all) begin
          m_mode = 0;
        end
      end
    endcase
    e_desk = (m_mode == 2);
  endfunction

  task automatic compare_model();
    logic [15:0] occ_act, occ_exp;
    logic [31:0] s0;
    logic        ok;
    check_bit("valid_o", valid_o, e_valid);
    check_bit("deskew_v_o", deskew_v_o, e_desk);
    if (e_valid) begin
      check_vec("block_o", block_o, e_block);
      check_bit("am_o", am_o, e_am);
    end
    // In ALIGNED the DUT pointer distance must track the buffered depth exactly.
    if (m_mode == 2) begin
      for (int i = 0; i < LN; i++) begin
        occ_act[i*4 +: 4] = 4'((int'(dut.wptr_q[i]) - int'(dut.rptr_q) + SK) % SK);
        occ_exp[i*4 +: 4] = 4'(mq[i].size() % SK);
        if (mq[i].size() < 1 || mq[i].size() > SK) occ_exp[i*4 +: 4] = 4'hF;
      end
      check_vec("occupancy", {{(LN*BW-16){1'b0}}, occ_act}, {{(LN*BW-16){1'b0}}, occ_exp});
    end
    if (seq_on && valid_o) begin
      ok = 1'b1;
      s0 = block_o[47:16];
      for (int i = 0; i < LN; i++) begin
        if (block_o[i*BW+48 +: 16] != 16'(i)) ok = 1'b0;
        if (block_o[i*BW+16 +: 32] != s0) ok = 1'b0;
      end
      if (last_seq >= 0) begin
        if (longint'(s0) != last_seq + 1) ok = 1'b0;
      end else if (!am_o || (s0 % AMP) != 0) begin
        ok = 1'b0;
      end
      check_bit("seq_align", ok, 1'b1);
      last_seq = longint'(s0);
    end
    if (!deskew_v_o) last_seq = -1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else model_step();
    #1;
    compare_model();
  endtask

  function automatic logic [LN*BW-1:0] tblk(input int r);
    logic [LN*BW-1:0] b;
    for (int i = 0; i < LN; i++) b[i*BW +: BW] = {2'b01, 32'(r), 32'(i)};
    return b;
  endfunction

  // sk holds one skew nibble per lane; vmode 0 continuous, 1 two-in-five pause, 2 random.
  // exp_align: 0 never aligns, 1 exact first-alignment timing, 2 must align at some point.
  task automatic run_stream(input logic [15:0] sk, input int ncyc, input int vmode,
                            input int drop_k, input int inj_k, input int exp_align);
    int   pos [LN];
    int   maxsk = 0;
    int   first_desk = -1;
    int   first_vo = -1;
    int   rises = 0;
    int   falls = 0;
    logic prev_desk;
    logic v;
    for (int i = 0; i < LN; i++) begin
      pos[i] = AMP - 3 - int'(sk[i*4 +: 4]);
      if (int'(sk[i*4 +: 4]) > maxsk) maxsk = int'(sk[i*4 +: 4]);
    end
    seq_on   = 1;
    last_seq = -1;
    lock_v_i = '0;
    valid_i  = 1'b1;
    am_v_i   = '0;
    block_i  = '0;
    tick();
    prev_desk = deskew_v_o;
    for (int k = 0; k < ncyc; k++) begin
      case (vmode)
        0:       v = 1'b1;
        1:       v = (k % 5) < 3;
        default: v = ($urandom_range(3) != 0);
      endcase
      valid_i  = v;
      lock_v_i = '1;
      if (k == drop_k) lock_v_i[2] = 1'b0;
      for (int i = 0; i < LN; i++) begin
        if (v) begin
          am_v_i[i] = ((pos[i] % AMP) == 0) || (k == inj_k && i == 1);
          block_i[i*BW +: BW] = {2'b10, 16'(i), 32'(pos[i]), 16'($urandom)};
          pos[i]++;
        end else begin
          am_v_i[i] = 1'($urandom);
          block_i[i*BW +: BW] = {2'($urandom), $urandom, $urandom};
        end
      end
      tick();
      if (deskew_v_o && !prev_desk) begin
        rises++;
        if (first_desk < 0) first_desk = k;
      end
      if (!deskew_v_o && prev_desk) falls++;
      if (valid_o && first_vo < 0) first_vo = k;
      if (k == drop_k) begin
        check_bit("drop_deskew", deskew_v_o, 1'b0);
        check_bit("drop_valid", valid_o, 1'b0);
      end
      prev_desk = deskew_v_o;
    end
    seq_on = 0;
    if (exp_align == 1) begin
      check_int("align_cycle", first_desk, 3 + maxsk);
      check_int("first_valid", first_vo, 4 + maxsk);
    end else if (exp_align == 0) begin
      check_int("no_align", rises, 0);
      check_int("no_valid", first_vo, -1);
    end else begin
      check_bit("aligned", rises >= 1, 1'b1);
    end
    if (drop_k >= 0 || inj_k >= 0) begin
      check_bit("refail", falls >= 1, 1'b1);
      check_bit("realign", rises >= 2, 1'b1);
    end
  endtask

  typedef struct {
    logic       v;
    logic [3:0] lock;
    logic [3:0] am;
    logic       ev;
    logic       eam;
    logic       edesk;
    int         src;
  } vec_t;

  vec_t tbl [14];

  initial begin
    tbl[0]  = '{1'b1, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, -1};
    tbl[1]  = '{1'b1, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, -1};
    tbl[2]  = '{1'b1, 4'hF, 4'hF, 1'b0, 1'b0, 1'b1, -1};
    tbl[3]  = '{1'b1, 4'hF, 4'h0, 1'b1, 1'b1, 1'b1,  2};
    tbl[4]  = '{1'b1, 4'hF, 4'h0, 1'b1, 1'b0, 1'b1,  3};
    tbl[5]  = '{1'b0, 4'hF, 4'h0, 1'b0, 1'b0, 1'b1, -1};
    tbl[6]  = '{1'b1, 4'hF, 4'h0, 1'b1, 1'b0, 1'b1,  4};
    tbl[7]  = '{1'b1, 4'hB, 4'h0, 1'b0, 1'b0, 1'b0, -1};
    tbl[8]  = '{1'b1, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, -1};
    tbl[9]  = '{1'b1, 4'hF, 4'hF, 1'b0, 1'b0, 1'b1, -1};
    tbl[10] = '{1'b1, 4'hF, 4'h0, 1'b1, 1'b1, 1'b1,  9};
    tbl[11] = '{1'b1, 4'hF, 4'h2, 1'b1, 1'b0, 1'b1, 10};
    tbl[12] = '{1'b1, 4'hF, 4'hD, 1'b0, 1'b0, 1'b0, -1};
    tbl[13] = '{1'b1, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, -1};

    reset    = 1'b1;
    valid_i  = 1'b0;
    lock_v_i = '0;
    am_v_i   = '0;
    block_i  = '0;
    tick();
    tick();
    check_bit("reset_valid", valid_o, 1'b0);
    check_bit("reset_am", am_o, 1'b0);
    check_bit("reset_deskew", deskew_v_o, 1'b0);
    check_vec("reset_block", block_o, '0);
    reset = 1'b0;

    for (int r = 0; r < 14; r++) begin
      valid_i  = tbl[r].v;
      lock_v_i = tbl[r].lock;
      am_v_i   = tbl[r].am;
      block_i  = tblk(r);
      tick();
      check_bit("tbl_valid", valid_o, tbl[r].ev);
      check_bit("tbl_deskew", deskew_v_o, tbl[r].edesk);
      if (tbl[r].ev) begin
        check_bit("tbl_am", am_o, tbl[r].eam);
        check_vec("tbl_block", block_o, tblk(tbl[r].src));
      end
    end

    run_stream(16'h0000,  40, 0, -1, -1, 1);
    run_stream(16'h5130, 120, 0, -1, -1, 1);
    run_stream(16'h7000,  60, 0, -1, -1, 1);
    run_stream(16'h8000,  60, 0, -1, -1, 0);
    run_stream(16'h6020,  60, 0, -1, -1, 1);
    run_stream(16'h5130, 150, 1, -1, -1, 2);
    run_stream(16'h5130, 100, 0, 60, -1, 1);
    run_stream(16'h0000,  80, 0, -1, 18, 1);

    for (int n = 0; n < 4; n++) begin
      logic [15:0] sk;
      int          dk;
      for (int i = 0; i < LN; i++) sk[i*4 +: 4] = 4'($urandom_range(7));
      dk = ($urandom_range(1) == 1) ? 70 + int'($urandom_range(20)) : -1;
      run_stream(sk, 110, 2, dk, -1, 2);
    end

    run_stream(16'h0000, 30, 0, -1, -1, 1);
    valid_i  = 1'b1;
    lock_v_i = '1;
    reset    = 1'b1;
    tick();
    check_bit("midreset_valid", valid_o, 1'b0);
    check_bit("midreset_am", am_o, 1'b0);
    check_bit("midreset_deskew", deskew_v_o, 1'b0);
    check_vec("midreset_block", block_o, '0);
    reset = 1'b0;
    run_stream(16'h0302, 40, 0, -1, -1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
